cp0_unit: RTL and testbench

- Parametrised Coprocessor-0 register file for the 5-stage MIPS core. Successor to the fixed 6-interrupt CP0.
- Adds:
  - configurable hardware-interrupt count and Count prescale;
  - a sticky timer interrupt (Cause.TI/IP7), cleared by a Compare write;
  - a registered interrupt-request output to the exception stage;
  - a fixed priority for the same-cycle write/exception/ERET interaction.
- Sits beside the MEM/WB boundary. Reads feed EX/MEM for MFC0; writes and exception commits arrive from the MEM stage.

---
 rtl/cp0_pkg.sv | 82 ++++++++
 rtl/cp0_timer.sv | 64 ++++++
 rtl/cp0_unit.sv | 161 ++++++++++++++++
 tb/tb_cp0_unit.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// ============================================================================
// Module      : cp0_pkg
// Description : Shared constants for the CP0 register file: register numbers,
//               field indices, ExcCodes, exception_type encoding, write masks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_pkg;

    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;
    localparam logic [4:0] CP0_REG_CONFIG0  = 5'd16;
    localparam logic [4:0] CP0_REG_CONFIG1  = 5'd17;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LO  = 8;
    localparam int STATUS_IM_HI  = 15;
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_EXC_HI  = 6;
    localparam int CAUSE_IP_LO   = 8;
    localparam int CAUSE_IP_HI   = 15;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_BD      = 31;

    localparam logic [4:0] EXC_CODE_INT  = 5'd0;
    localparam logic [4:0] EXC_CODE_ADEL = 5'd4;
    localparam logic [4:0] EXC_CODE_ADES = 5'd5;
    localparam logic [4:0] EXC_CODE_SYS  = 5'd8;
    localparam logic [4:0] EXC_CODE_BP   = 5'd9;
    localparam logic [4:0] EXC_CODE_RI   = 5'd10;
    localparam logic [4:0] EXC_CODE_OV   = 5'd12;

    localparam int EXC_TYPE_W = 4;
    localparam logic [EXC_TYPE_W-1:0] EXC_TYPE_NONE = 4'd0;
    localparam logic [EXC_TYPE_W-1:0] EXC_TYPE_INT  = 4'd1;
    localparam logic [EXC_TYPE_W-1:0] EXC_TYPE_IF   = 4'd2;
    localparam logic [EXC_TYPE_W-1:0] EXC_TYPE_ADEL = 4'd3;
    localparam logic [EXC_TYPE_W-1:0] EXC_TYPE_ADES = 4'd4;
    localparam logic [EXC_TYPE_W-1:0] EXC_TYPE_SYS  = 4'd5;
    localparam logic [EXC_TYPE_W-1:0] EXC_TYPE_BP   = 4'd6;
    localparam logic [EXC_TYPE_W-1:0] EXC_TYPE_RI   = 4'd7;
    localparam logic [EXC_TYPE_W-1:0] EXC_TYPE_OV   = 4'd8;
    localparam logic [EXC_TYPE_W-1:0] EXC_TYPE_ERET = 4'd9;

    localparam logic [31:0] WMASK_STATUS  = 32'h0040_FF03;
    localparam logic [31:0] WMASK_CAUSE   = 32'h0000_0300;
    localparam logic [31:0] WMASK_FULL    = 32'hFFFF_FFFF;
    localparam logic [31:0] WMASK_CONFIG0 = 32'h0000_0007;

    function automatic logic [4:0] exc_code_of(input logic [EXC_TYPE_W-1:0] t);
        case (t)
            EXC_TYPE_IF, EXC_TYPE_ADEL: exc_code_of = EXC_CODE_ADEL;
            EXC_TYPE_ADES:              exc_code_of = EXC_CODE_ADES;
            EXC_TYPE_SYS:               exc_code_of = EXC_CODE_SYS;
            EXC_TYPE_BP:                exc_code_of = EXC_CODE_BP;
            EXC_TYPE_RI:                exc_code_of = EXC_CODE_RI;
            EXC_TYPE_OV:                exc_code_of = EXC_CODE_OV;
            default:                    exc_code_of = EXC_CODE_INT;
        endcase
    endfunction

    function automatic logic [31:0] wmask_of(input logic [4:0] addr);
        case (addr)
            CP0_REG_STATUS:  wmask_of = WMASK_STATUS;
            CP0_REG_CAUSE:   wmask_of = WMASK_CAUSE;
            CP0_REG_COUNT,
            CP0_REG_COMPARE,
            CP0_REG_EPC:     wmask_of = WMASK_FULL;
            CP0_REG_CONFIG0: wmask_of = WMASK_CONFIG0;
            default:         wmask_of = 32'h0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_timer.sv
// ============================================================================
// Module      : cp0_timer
// Description : Count prescaler, Count/Compare registers and sticky timer flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    localparam int            PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [31:0]   r_count;
    logic [31:0]   r_compare;
    logic          r_ti;
    logic          w_inc;

    // A Count write cancels the increment that would otherwise happen this cycle.
    assign w_inc = (r_presc == PRESC_MAX) & ~count_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc   <= '0;
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else begin
            if (count_we) begin
                r_count <= wdata;
                r_presc <= '0;
            end else begin
                r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;
                if (w_inc) begin
                    r_count <= r_count + 32'd1;
                end
            end
            if (compare_we) begin
                r_compare <= wdata;
                r_ti      <= 1'b0;
            end else if (w_inc && (r_count == r_compare)) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign count     = r_count;
    assign compare   = r_compare;
    assign timer_int = r_ti;

endmodule

`default_nettype wire

// File: rtl/cp0_unit.sv
// ============================================================================
// Module      : cp0_unit
// Description : Parametrised CP0 register file with timer, exception commit
//               and registered interrupt request. Optional CP0_WRITE_BYPASS_EN
//               forwards a same-cycle MTC0 onto the MFC0 read path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_unit
    import cp0_pkg::*;
#(
    parameter int          HW_INT_NUM   = 6,
    parameter int          COUNT_DIV    = 2,
    parameter logic [31:0] STATUS_RST   = 32'h0040_0000,
    parameter logic [31:0] CONFIG0_RST  = 32'h8000_0003,
    parameter int          TIMER_IP_BIT = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cp0_write_en,
    input  logic [4:0]            cp0_write_addr,
    input  logic [31:0]           cp0_write_data,
    input  logic [4:0]            cp0_read_addr,
    input  logic [HW_INT_NUM-1:0] interrupt_i,
    input  logic [EXC_TYPE_W-1:0] exception_type,
    input  logic                  delayslot_flag,
    input  logic [31:0]           current_pc_addr,
    input  logic [31:0]           cp0_badvaddr_write_data,
    output logic [31:0]           data_o,
    output logic [31:0]           count_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic [31:0]           config0_o,
    output logic                  int_req_o
);

    logic [31:0]           r_badvaddr, r_status, r_epc, r_config0;
    logic                  r_cause_bd;
    logic [4:0]            r_cause_exc;
    logic [1:0]            r_ip_sw;
    logic [HW_INT_NUM-1:0] r_ip_hw;
    logic                  r_int_req;

    logic [31:0] w_count, w_compare, w_cause, w_rd_cur;
    logic [7:0]  w_ip;
    logic        w_timer_int, w_exc_take, w_eret, w_exl, w_addr_exc;
    logic        w_wr_count, w_wr_compare, w_wr_status, w_wr_cause, w_wr_epc, w_wr_config0;

    assign w_wr_count   = cp0_write_en && (cp0_write_addr == CP0_REG_COUNT);
    assign w_wr_compare = cp0_write_en && (cp0_write_addr == CP0_REG_COMPARE);
    assign w_wr_status  = cp0_write_en && (cp0_write_addr == CP0_REG_STATUS);
    assign w_wr_cause   = cp0_write_en && (cp0_write_addr == CP0_REG_CAUSE);
    assign w_wr_epc     = cp0_write_en && (cp0_write_addr == CP0_REG_EPC);
    assign w_wr_config0 = cp0_write_en && (cp0_write_addr == CP0_REG_CONFIG0);

    assign w_eret     = (exception_type == EXC_TYPE_ERET);
    assign w_exc_take = (exception_type != EXC_TYPE_NONE) && !w_eret;
    assign w_addr_exc = (exception_type == EXC_TYPE_IF) || (exception_type == EXC_TYPE_ADEL) ||
                        (exception_type == EXC_TYPE_ADES);
    assign w_exl      = r_status[STATUS_EXL];

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (w_wr_count),
        .compare_we (w_wr_compare),
        .wdata      (cp0_write_data),
        .count      (w_count),
        .compare    (w_compare),
        .timer_int  (w_timer_int)
    );

    // The timer shares its IP bit with any external line mapped onto it.
    always_comb begin
        w_ip                  = '0;
        w_ip[1:0]             = r_ip_sw;
        w_ip[2 +: HW_INT_NUM] = r_ip_hw;
        w_ip[TIMER_IP_BIT]    = w_ip[TIMER_IP_BIT] | w_timer_int;
    end

    assign w_cause = {r_cause_bd, w_timer_int, 14'b0, w_ip, 1'b0, r_cause_exc, 2'b0};

    // Exception/ERET assignments come last so they override MTC0 on shared bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_badvaddr  <= '0;
            r_status    <= STATUS_RST;
            r_epc       <= '0;
            r_config0   <= CONFIG0_RST;
            r_cause_bd  <= 1'b0;
            r_cause_exc <= '0;
            r_ip_sw     <= '0;
            r_ip_hw     <= '0;
            r_int_req   <= 1'b0;
        end else begin
            r_ip_hw <= interrupt_i;
            if (w_wr_cause)   r_ip_sw   <= cp0_write_data[9:8];
            if (w_wr_status)  r_status  <= (r_status & ~WMASK_STATUS) | (cp0_write_data & WMASK_STATUS);
            if (w_wr_epc)     r_epc     <= cp0_write_data;
            if (w_wr_config0) r_config0 <= (r_config0 & ~WMASK_CONFIG0) | (cp0_write_data & WMASK_CONFIG0);
            if (w_exc_take) begin
                r_status[STATUS_EXL] <= 1'b1;
                r_cause_exc          <= exc_code_of(exception_type);
                if (!w_exl) begin
                    r_epc      <= delayslot_flag ? current_pc_addr - 32'd4 : current_pc_addr;
                    r_cause_bd <= delayslot_flag;
                end
                if (w_addr_exc) r_badvaddr <= cp0_badvaddr_write_data;
            end else if (w_eret) begin
                r_status[STATUS_EXL] <= 1'b0;
            end
            r_int_req <= !w_exc_take && r_status[STATUS_IE] && !w_exl &&
                         |(w_ip & r_status[STATUS_IM_HI:STATUS_IM_LO]);
        end
    end

    always_comb begin
        w_rd_cur = '0;
        case (cp0_read_addr)
            CP0_REG_BADVADDR: w_rd_cur = r_badvaddr;
            CP0_REG_COUNT:    w_rd_cur = w_count;
            CP0_REG_COMPARE:  w_rd_cur = w_compare;
            CP0_REG_STATUS:   w_rd_cur = r_status;
            CP0_REG_CAUSE:    w_rd_cur = w_cause;
            CP0_REG_EPC:      w_rd_cur = r_epc;
            CP0_REG_CONFIG0:  w_rd_cur = r_config0;
            CP0_REG_CONFIG1:  w_rd_cur = 32'h0;
            default:          w_rd_cur = '0;
        endcase
    end

    always_comb begin
        data_o = '0;
        if (!rst) begin
`ifdef CP0_WRITE_BYPASS_EN
            if (cp0_write_en && (cp0_write_addr == cp0_read_addr)) begin
                data_o = (w_rd_cur & ~wmask_of(cp0_read_addr)) |
                         (cp0_write_data & wmask_of(cp0_read_addr));
            end else begin
                data_o = w_rd_cur;
            end
`else
            data_o = w_rd_cur;
`endif
        end
    end

    assign count_o   = w_count;
    assign status_o  = r_status;
    assign cause_o   = w_cause;
    assign epc_o     = r_epc;
    assign config0_o = r_config0;
    assign int_req_o = r_int_req;

endmodule

`default_nettype wire

// File: tb/tb_cp0_unit.sv
// ============================================================================
// Module      : tb_cp0_unit
// Description : Self-checking bench for cp0_unit: directed steps followed by a
//               randomized run compared against a rule-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cp0_unit;
    import cp0_pkg::*;

    localparam int DIV = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cp0_write_en;
    logic [4:0]  cp0_write_addr;
    logic [31:0] cp0_write_data;
    logic [4:0]  cp0_read_addr;
    logic [5:0]  interrupt_i;
    logic [EXC_TYPE_W-1:0] exception_type;
    logic        delayslot_flag;
    logic [31:0] current_pc_addr;
    logic [31:0] cp0_badvaddr_write_data;
    logic [31:0] data_o, count_o, status_o, cause_o, epc_o, config0_o;
    logic        int_req_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_count, m_compare, m_status, m_epc, m_badv, m_config0;
    int          m_phase;
    logic        m_ti, m_bd, m_intreq;
    logic [4:0]  m_exc;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_iphw;

    cp0_unit dut (
        .clk                     (clk),
        .rst                     (rst),
        .cp0_write_en            (cp0_write_en),
        .cp0_write_addr          (cp0_write_addr),
        .cp0_write_data          (cp0_write_data),
        .cp0_read_addr           (cp0_read_addr),
        .interrupt_i             (interrupt_i),
        .exception_type          (exception_type),
        .delayslot_flag          (delayslot_flag),
        .current_pc_addr         (current_pc_addr),
        .cp0_badvaddr_write_data (cp0_badvaddr_write_data),
        .data_o                  (data_o),
        .count_o                 (count_o),
        .status_o                (status_o),
        .cause_o                 (cause_o),
        .epc_o                   (epc_o),
        .config0_o               (config0_o),
        .int_req_o               (int_req_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_cause();
        logic [7:0] ip;
        ip    = {m_iphw, 2'b00} | {6'b0, m_ipsw};
        ip[7] = ip[7] | m_ti;
        return {m_bd, m_ti, 14'b0, ip, 1'b0, m_exc, 2'b00};
    endfunction

    function automatic logic [31:0] bench_mask(input logic [4:0] a);
        case (a)
            5'd12:               return 32'h0040_FF03;
            5'd13:               return 32'h0000_0300;
            5'd9, 5'd11, 5'd14:  return 32'hFFFF_FFFF;
            5'd16:               return 32'h0000_0007;
            default:             return 32'h0;
        endcase
    endfunction

    function automatic logic [4:0] bench_code(input logic [EXC_TYPE_W-1:0] t);
        case (t)
            EXC_TYPE_INT:              return 5'd0;
            EXC_TYPE_IF, EXC_TYPE_ADEL: return 5'd4;
            EXC_TYPE_ADES:             return 5'd5;
            EXC_TYPE_SYS:              return 5'd8;
            EXC_TYPE_BP:               return 5'd9;
            EXC_TYPE_RI:               return 5'd10;
            EXC_TYPE_OV:               return 5'd12;
            default:                   return 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] v;
        if (rst) return 32'h0;
        case (a)
            5'd8:    v = m_badv;
            5'd9:    v = m_count;
            5'd11:   v = m_compare;
            5'd12:   v = m_status;
            5'd13:   v = m_cause();
            5'd14:   v = m_epc;
            5'd16:   v = m_config0;
            default: v = 32'h0;
        endcase
`ifdef CP0_WRITE_BYPASS_EN
        if (cp0_write_en && cp0_write_addr == a)
            v = (v & ~bench_mask(a)) | (cp0_write_data & bench_mask(a));
`endif
        return v;
    endfunction

    // Advances the model by one clock using the inputs present at the edge.
    task automatic model_step();
        logic exc, eret, old_exl, req, inc, wr_cnt, wr_cmp, nti;
        logic [31:0] c;
        if (rst) begin
            m_count = 0; m_compare = 0; m_status = 32'h0040_0000; m_epc = 0; m_badv = 0;
            m_config0 = 32'h8000_0003; m_phase = 0; m_ti = 0; m_bd = 0; m_intreq = 0;
            m_exc = 0; m_ipsw = 0; m_iphw = 0;
            return;
        end
        eret    = (exception_type == EXC_TYPE_ERET);
        exc     = (exception_type != EXC_TYPE_NONE) && !eret;
        old_exl = m_status[1];
        c       = m_cause();
        req     = m_status[0] && !old_exl && ((c[15:8] & m_status[15:8]) != 0);
        wr_cnt  = cp0_write_en && cp0_write_addr == 5'd9;
        wr_cmp  = cp0_write_en && cp0_write_addr == 5'd11;
        inc     = (m_phase == DIV - 1) && !wr_cnt;
        nti     = m_ti;
        if (inc && m_count == m_compare) nti = 1;
        if (wr_cmp) nti = 0;
        if (wr_cnt) begin
            m_count = cp0_write_data; m_phase = 0;
        end else begin
            m_phase = (m_phase + 1) % DIV;
            if (inc) m_count = m_count + 1;
        end
        if (wr_cmp) m_compare = cp0_write_data;
        m_ti     = nti;
        m_intreq = req && !exc;
        m_iphw   = interrupt_i;
        if (cp0_write_en) begin
            case (cp0_write_addr)
                5'd12: m_status  = (m_status & ~bench_mask(5'd12)) | (cp0_write_data & bench_mask(5'd12));
                5'd13: m_ipsw    = cp0_write_data[9:8];
                5'd14: m_epc     = cp0_write_data;
                5'd16: m_config0 = (m_config0 & ~32'h7) | (cp0_write_data & 32'h7);
                default: ;
            endcase
        end
        if (exc) begin
            if (!old_exl) begin
                m_epc = delayslot_flag ? current_pc_addr - 4 : current_pc_addr;
                m_bd  = delayslot_flag;
            end
            m_exc       = bench_code(exception_type);
            m_status[1] = 1'b1;
            if (exception_type inside {EXC_TYPE_IF, EXC_TYPE_ADEL, EXC_TYPE_ADES})
                m_badv = cp0_badvaddr_write_data;
        end else if (eret) begin
            m_status[1] = 1'b0;
        end
    endtask

    task automatic cyc();
        #1;
        chk("data_o", data_o, model_read(cp0_read_addr));
        @(posedge clk);
        model_step();
        #1;
        chk("count", count_o, m_count);
        chk("status", status_o, m_status);
        chk("cause", cause_o, m_cause());
        chk("epc", epc_o, m_epc);
        chk("config0", config0_o, m_config0);
        chk("int_req", {31'b0, int_req_o}, {31'b0, m_intreq});
    endtask

    task automatic idle();
        cp0_write_en = 0; cp0_write_addr = 0; cp0_write_data = 0;
        exception_type = EXC_TYPE_NONE; delayslot_flag = 0;
        current_pc_addr = 0; cp0_badvaddr_write_data = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_write_en = 1; cp0_write_addr = a; cp0_write_data = d;
        cyc();
        idle();
    endtask

    initial begin
        logic [4:0] addrs [10];
        addrs = '{5'd3, 5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd16, 5'd17, 5'd31};
        idle();
        rst = 1; interrupt_i = 0; cp0_read_addr = 5'd12;
        cyc(); cyc();
        chk("rst_status", status_o, 32'h0040_0000);
        chk("rst_count", count_o, 32'h0);
        chk("rst_int_req", {31'b0, int_req_o}, 32'h0);

        rst = 0;
        repeat (20) cyc();
        chk("count_after_20", count_o, 32'd10);

        // Timer match at Compare=5
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd5);
        for (int i = 0; i < 40; i++) begin
            if (count_o == 32'd7) break;
            cyc();
        end
        chk("count_reached_7", count_o, 32'd7);
        chk("ti_sticky", {31'b0, cause_o[30]}, 32'd1);
        chk("ip7_sticky", {31'b0, cause_o[15]}, 32'd1);
        mtc0(5'd11, 32'd100);
        chk("ti_cleared", {31'b0, cause_o[30]}, 32'd0);
        chk("ip7_cleared", {31'b0, cause_o[15]}, 32'd0);

        // External interrupt then INT commit in a delay slot
        mtc0(5'd12, 32'h0000_0401);
        interrupt_i = 6'b000001;
        cyc(); cyc();
        chk("int_req_raised", {31'b0, int_req_o}, 32'd1);
        exception_type = EXC_TYPE_INT; current_pc_addr = 32'hBFC0_0100; delayslot_flag = 1;
        cyc(); idle();
        chk("int_epc", epc_o, 32'hBFC0_00FC);
        chk("int_bd", {31'b0, cause_o[31]}, 32'd1);
        chk("int_exccode", {27'b0, cause_o[6:2]}, 32'd0);
        chk("int_exl", {31'b0, status_o[1]}, 32'd1);
        chk("int_req_dropped", {31'b0, int_req_o}, 32'd0);
        exception_type = EXC_TYPE_ERET;
        cyc(); idle();
        interrupt_i = 0;

        // ADEL racing an MTC0 Status=0
        exception_type = EXC_TYPE_ADEL; current_pc_addr = 32'h8000_0010;
        cp0_badvaddr_write_data = 32'h8000_0013;
        cp0_write_en = 1; cp0_write_addr = 5'd12; cp0_write_data = 32'h0;
        cyc(); idle();
        cp0_read_addr = 5'd8;
        #1 chk("adel_badvaddr", data_o, 32'h8000_0013);
        chk("adel_exccode", {27'b0, cause_o[6:2]}, 32'd4);
        chk("adel_exl", {31'b0, status_o[1]}, 32'd1);
        chk("adel_ie", {31'b0, status_o[0]}, 32'd0);

        // Nested SYS keeps EPC
        exception_type = EXC_TYPE_SYS; current_pc_addr = 32'h0000_2000;
        cyc(); idle();
        chk("nested_epc", epc_o, 32'h8000_0010);
        chk("nested_exccode", {27'b0, cause_o[6:2]}, 32'd8);
        exception_type = EXC_TYPE_ERET;
        cyc(); idle();
        chk("eret_exl", {31'b0, status_o[1]}, 32'd0);

        cp0_read_addr = 5'd3;
        #1 chk("unmapped_read", data_o, 32'h0);

        cp0_write_en = 1; cp0_write_addr = 5'd14; cp0_write_data = 32'h1234_5678;
        cp0_read_addr = 5'd14;
`ifdef CP0_WRITE_BYPASS_EN
        #1 chk("bypass_epc", data_o, 32'h1234_5678);
`else
        #1 chk("no_bypass_epc", data_o, 32'h8000_0010);
`endif
        cyc(); idle();

        // Randomized run
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            idle();
            interrupt_i   = 6'($urandom);
            cp0_read_addr = addrs[$urandom_range(0, 9)];
            if (r < 30) begin
                cp0_write_en   = 1;
                cp0_write_addr = addrs[$urandom_range(0, 9)];
                cp0_write_data = (cp0_write_addr == 5'd11) ? m_count + $urandom_range(0, 8) : $urandom;
            end
            if (r >= 20 && r < 35) begin
                exception_type          = EXC_TYPE_W'($urandom_range(1, 9));
                current_pc_addr         = $urandom & 32'hFFFF_FFFC;
                delayslot_flag          = 1'($urandom);
                cp0_badvaddr_write_data = $urandom;
            end
            cyc();
        end

        // Reset during an exception commit discards it
        idle();
        rst = 1; exception_type = EXC_TYPE_SYS; current_pc_addr = 32'h0000_4444;
        cyc();
        rst = 0; idle();
        chk("rst_exc_epc", epc_o, 32'h0);
        chk("rst_exc_cause", cause_o, 32'h0);
        chk("rst_exc_status", status_o, 32'h0040_0000);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
